// File: rtl/stack_queue_alu.sv
// stack_queue_alu: parametrised LIFO/FIFO store with a two-operand ALU and valid/ready command port
module stack_queue_alu #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err,
    output logic              carry,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] OP_PUSH = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                           OP_AND = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6, OP_CLR = 3'd7;
    typedef enum logic [2:0] {IDLE, POP1, POP2, EXEC, DONE} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail, pop_addr;
    logic mode_q, bad_cmd, wr_en;
    logic [2:0] op_q;
    logic [DATA_W-1:0] x_q, y_q, pop_data, wr_data;
    logic [DATA_W:0] res;

    assign cmd_ready = state == IDLE;
    assign empty = count == '0;
    assign full = count == CNT_W'(DEPTH);
    // stack pops from the slot below tail, queue pops from head; result keeps one extra bit for carry/borrow
    always_comb begin
        pop_addr = mode_q ? head : tail - 1'b1;
        pop_data = mem[pop_addr];
        res = op_q == OP_ADD ? {1'b0, y_q} + {1'b0, x_q} :
              op_q == OP_SUB ? {1'b0, y_q} - {1'b0, x_q} :
              op_q == OP_AND ? {1'b0, y_q & x_q} :
              op_q == OP_OR  ? {1'b0, y_q | x_q} : {1'b0, y_q ^ x_q};
        bad_cmd = cmd_op == OP_PUSH ? full :
                  cmd_op == OP_POP  ? empty :
                  cmd_op == OP_CLR  ? 1'b0 : count < CNT_W'(2);
        wr_en = state == EXEC || (state == IDLE && cmd_valid && cmd_op == OP_PUSH && !full);
        wr_data = state == EXEC ? res[DATA_W-1:0] : din;
    end

    // both PUSH and the ALU result land at tail
    always_ff @(posedge clk) begin
        if (wr_en) mem[tail] <= wr_data;
    end

    // command FSM: rejects illegal commands at accept, otherwise pops operands then executes
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            mode_q <= 1'b0;
            dout <= '0;
            done <= 1'b0;
            err <= 1'b0;
            carry <= 1'b0;
            op_q <= OP_PUSH;
            x_q <= '0;
            y_q <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (count == '0) mode_q <= mode;
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        if (bad_cmd) begin
                            err <= 1'b1;
                            done <= 1'b1;
                            state <= DONE;
                        end else if (cmd_op == OP_PUSH) begin
                            tail <= tail + 1'b1;
                            count <= count + 1'b1;
                            dout <= din;
                            done <= 1'b1;
                            state <= DONE;
                        end else if (cmd_op == OP_CLR) begin
                            head <= '0;
                            tail <= '0;
                            count <= '0;
                            done <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= POP1;
                        end
                    end
                end
                POP1, POP2: begin
                    if (state == POP1) x_q <= pop_data;
                    else y_q <= pop_data;
                    if (op_q == OP_POP) dout <= pop_data;
                    if (mode_q) head <= head + 1'b1;
                    else tail <= tail - 1'b1;
                    count <= count - 1'b1;
                    done <= op_q == OP_POP;
                    state <= op_q == OP_POP ? DONE : state == POP1 ? POP2 : EXEC;
                end
                EXEC: begin
                    tail <= tail + 1'b1;
                    count <= count + 1'b1;
                    dout <= res[DATA_W-1:0];
                    carry <= res[DATA_W];
                    done <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_queue_alu.sv
// tb_stack_queue_alu: directed commands feed a scoreboard; a monitor checks every done pulse
module tb_stack_queue_alu;
    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, CLR = 3'd7;
    logic clk = 0, rst = 1, mode = 0, cmd_valid = 0, cmd_ready, done, err, carry, empty, full;
    logic [2:0] cmd_op = 0;
    logic [15:0] din = 0, dout;
    logic [5:0] count;
    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    typedef struct { logic [15:0] d; logic e; logic c; int n; int l; } exp_t;
    exp_t sb[$];

    stack_queue_alu dut (.clk(clk), .rst(rst), .mode(mode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .din(din), .dout(dout), .done(done), .err(err), .carry(carry),
        .count(count), .empty(empty), .full(full));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // monitor: every done pulse consumes one expected response
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", int'(dout), int'(e.d));
                chk("err", int'(err), int'(e.e));
                chk("carry", int'(carry), int'(e.c));
                chk("count", int'(count), e.n);
                chk("latency", cyc - acc_cyc + 1, e.l);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] d, input logic [15:0] ed,
                         input logic ee, input logic ec, input int en, input int el);
        int n;
        sb.push_back('{ed, ee, ec, en, el});
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; din = d;
        @(posedge clk);
        #1 acc_cyc = cyc; cmd_valid = 0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] s;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_count", int'(count), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        // stack fill and overflow
        for (int i = 1; i <= 32; i++) issue(PUSH, 16'(i), 16'(i), 0, 0, i, 1);
        chk("stack_full", int'(full), 1);
        issue(PUSH, 16'd99, 16'd32, 1, 0, 32, 1);
        // stack ADD chain
        s = 16'd32;
        for (int k = 1; k <= 31; k++) begin
            s = s + 16'(32 - k);
            issue(ADD, 0, s, 0, 0, 32 - k, 4);
        end
        chk("chain_sum", int'(dout), 528);
        // stack SUB borrow
        issue(CLR, 0, 16'd528, 0, 0, 0, 1);
        issue(PUSH, 16'd5, 16'd5, 0, 0, 1, 1);
        issue(PUSH, 16'd7, 16'd7, 0, 0, 2, 1);
        issue(SUB, 0, 16'hFFFE, 0, 1, 1, 4);
        issue(POP, 0, 16'hFFFE, 0, 1, 0, 2);
        chk("sub_empty", int'(empty), 1);
        issue(POP, 0, 16'hFFFE, 1, 1, 0, 1);
        // queue order
        mode = 1;
        issue(CLR, 0, 16'hFFFE, 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) issue(PUSH, 16'(i), 16'(i), 0, 1, i, 1);
        issue(ADD, 0, 16'd3, 0, 0, 3, 4);
        issue(POP, 0, 16'd3, 0, 0, 2, 2);
        issue(POP, 0, 16'd4, 0, 0, 1, 2);
        issue(POP, 0, 16'd3, 0, 0, 0, 2);
        // queue logic ops, ADD carry, SUB operand order
        issue(PUSH, 16'h0F0F, 16'h0F0F, 0, 0, 1, 1);
        issue(PUSH, 16'h00FF, 16'h00FF, 0, 0, 2, 1);
        issue(AND_, 0, 16'h000F, 0, 0, 1, 4);
        issue(PUSH, 16'h1230, 16'h1230, 0, 0, 2, 1);
        issue(OR_, 0, 16'h123F, 0, 0, 1, 4);
        issue(PUSH, 16'h0F00, 16'h0F00, 0, 0, 2, 1);
        issue(XOR_, 0, 16'h1D3F, 0, 0, 1, 4);
        issue(POP, 0, 16'h1D3F, 0, 0, 0, 2);
        issue(PUSH, 16'hFFFF, 16'hFFFF, 0, 0, 1, 1);
        issue(PUSH, 16'h0002, 16'h0002, 0, 0, 2, 1);
        issue(ADD, 0, 16'h0001, 0, 1, 1, 4);
        issue(PUSH, 16'h0005, 16'h0005, 0, 1, 2, 1);
        issue(SUB, 0, 16'h0004, 0, 0, 1, 4);
        issue(POP, 0, 16'h0004, 0, 0, 0, 2);
        // queue wrap-around
        for (int i = 1; i <= 32; i++) issue(PUSH, 16'(i), 16'(i), 0, 0, i, 1);
        for (int i = 1; i <= 10; i++) issue(POP, 0, 16'(i), 0, 0, 32 - i, 2);
        for (int i = 33; i <= 42; i++) issue(PUSH, 16'(i), 16'(i), 0, 0, i - 10, 1);
        chk("wrap_full", int'(full), 1);
        for (int i = 11; i <= 42; i++) issue(POP, 0, 16'(i), 0, 0, 42 - i, 2);
        chk("wrap_empty", int'(empty), 1);
        // reset during POP2 of an ADD
        issue(CLR, 0, 16'd42, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) issue(PUSH, 16'(i), 16'(i), 0, 0, i, 1);
        @(negedge clk);
        cmd_valid = 1; cmd_op = ADD;
        @(posedge clk);
        #1 cmd_valid = 0;
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("midrst_count", int'(count), 0);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_done", int'(done), 0);
        issue(PUSH, 16'd9, 16'd9, 0, 0, 1, 1);
        issue(ADD, 0, 16'd9, 1, 0, 1, 1);
        repeat (3) @(negedge clk);
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
